// File: rtl/rv32i_pkg.sv
// RV32I shared definitions: base opcodes, immediate formats and opcode classification helpers.
package rv32i_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_fmt_e;

   function automatic imm_fmt_e fmt_of(input logic [6:0] op);
      imm_fmt_e f;
      case (op)
         OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_FENCE: f = IMM_I;
         OP_STORE:                                      f = IMM_S;
         OP_BRANCH:                                     f = IMM_B;
         OP_LUI, OP_AUIPC:                              f = IMM_U;
         OP_JAL:                                        f = IMM_J;
         default:                                       f = IMM_NONE;
      endcase
      return f;
   endfunction

   function automatic logic op_legal(input logic [6:0] op);
      logic ok;
      case (op)
         OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC,
         OP_JAL, OP_JALR, OP_REG, OP_SYSTEM, OP_FENCE: ok = 1'b1;
         default:                                      ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/etapa_decodificacion_generador_inmediato.sv
// Combinational immediate generator: sign-extended immediate, format and illegal-opcode flag.
module generador_inmediato
   import rv32i_pkg::*;
(
   input  logic [31:0] i_instr,
   output logic [31:0] o_imm,
   output imm_fmt_e    o_fmt,
   output logic        o_illegal
);

   logic [6:0] w_op;
   logic       w_sgn;

   assign w_op  = i_instr[6:0];
   assign w_sgn = i_instr[31];

   always_comb begin
      o_fmt     = fmt_of(w_op);
      o_illegal = !op_legal(w_op);
      o_imm     = '0;
      case (o_fmt)
         IMM_I: o_imm = {{20{w_sgn}}, i_instr[31:20]};
         IMM_S: o_imm = {{20{w_sgn}}, i_instr[31:25], i_instr[11:7]};
         IMM_B: o_imm = {{19{w_sgn}}, w_sgn, i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
         IMM_U: o_imm = {i_instr[31:12], 12'h000};
         IMM_J: o_imm = {{11{w_sgn}}, w_sgn, i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
         default: o_imm = '0;
      endcase
   end

endmodule

// File: rtl/etapa_decodificacion.sv
// RV32I decode stage: register-file read, operand capture, immediate generation, one-deep output register.
// DECOD_BYPASS_EN selects writeback forwarding; otherwise a writeback hazard stalls acceptance for a cycle.
module etapa_decodificacion
   import rv32i_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [XLEN-1:0]   in_pc,
   output logic [REG_AW-1:0] rf_addr1,
   output logic [REG_AW-1:0] rf_addr2,
   input  logic [XLEN-1:0]   rf_datos1,
   input  logic [XLEN-1:0]   rf_datos2,
   input  logic              wb_valid,
   input  logic [REG_AW-1:0] wb_addr,
   input  logic [XLEN-1:0]   wb_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [XLEN-1:0]   out_pc,
   output logic [XLEN-1:0]   out_rs1_val,
   output logic [XLEN-1:0]   out_rs2_val,
   output logic [XLEN-1:0]   out_imm,
   output logic [REG_AW-1:0] out_rd,
   output logic [6:0]        out_opcode,
   output logic [2:0]        out_funct3,
   output logic              out_funct7b5,
   output logic              out_illegal
);

   logic [REG_AW-1:0] w_rs1, w_rs2, w_rd;
   logic [XLEN-1:0]   w_op1, w_op2;
   logic [31:0]       w_imm;
   imm_fmt_e          w_fmt;
   logic              w_illegal, w_stall, w_accept;

   logic              r_valid;
   logic [XLEN-1:0]   r_pc, r_rs1_val, r_rs2_val, r_imm;
   logic [REG_AW-1:0] r_rd;
   logic [6:0]        r_opcode;
   logic [2:0]        r_funct3;
   logic              r_funct7b5, r_illegal;

   assign w_rs1    = in_instr[19:15];
   assign w_rs2    = in_instr[24:20];
   assign rf_addr1 = w_rs1;
   assign rf_addr2 = w_rs2;

   generador_inmediato u_gen_imm (
      .i_instr   (in_instr),
      .o_imm     (w_imm),
      .o_fmt     (w_fmt),
      .o_illegal (w_illegal)
   );

`ifdef DECOD_BYPASS_EN
   always_comb begin
      w_stall = 1'b0;
      w_op1   = rf_datos1;
      w_op2   = rf_datos2;
      if (w_rs1 == '0)                            w_op1 = '0;
      else if (wb_valid && (wb_addr == w_rs1))    w_op1 = wb_data;
      if (w_rs2 == '0)                            w_op2 = '0;
      else if (wb_valid && (wb_addr == w_rs2))    w_op2 = wb_data;
   end
`else
   // Without forwarding, wait one cycle so the register file returns the committed value.
   logic w_unused_wb_data;
   assign w_unused_wb_data = ^wb_data;

   always_comb begin
      w_stall = in_valid && wb_valid && (wb_addr != '0) &&
                ((wb_addr == w_rs1) || (wb_addr == w_rs2));
      w_op1   = (w_rs1 == '0) ? '0 : rf_datos1;
      w_op2   = (w_rs2 == '0) ? '0 : rf_datos2;
   end
`endif

   assign in_ready = !flush && !w_stall && (!r_valid || out_ready);
   assign w_accept = in_valid && in_ready;
   assign w_rd     = (w_illegal || (w_fmt == IMM_S) || (w_fmt == IMM_B)) ? '0 : in_instr[11:7];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid    <= 1'b0;
         r_pc       <= '0;
         r_rs1_val  <= '0;
         r_rs2_val  <= '0;
         r_imm      <= '0;
         r_rd       <= '0;
         r_opcode   <= '0;
         r_funct3   <= '0;
         r_funct7b5 <= 1'b0;
         r_illegal  <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
      end else if (w_accept) begin
         r_valid    <= 1'b1;
         r_pc       <= in_pc;
         r_rs1_val  <= w_op1;
         r_rs2_val  <= w_op2;
         r_imm      <= w_illegal ? '0 : w_imm;
         r_rd       <= w_rd;
         r_opcode   <= in_instr[6:0];
         r_funct3   <= in_instr[14:12];
         r_funct7b5 <= in_instr[30];
         r_illegal  <= w_illegal;
      end else if (out_ready) begin
         r_valid <= 1'b0;
      end
   end

   assign out_valid    = r_valid;
   assign out_pc       = r_pc;
   assign out_rs1_val  = r_rs1_val;
   assign out_rs2_val  = r_rs2_val;
   assign out_imm      = r_imm;
   assign out_rd       = r_rd;
   assign out_opcode   = r_opcode;
   assign out_funct3   = r_funct3;
   assign out_funct7b5 = r_funct7b5;
   assign out_illegal  = r_illegal;

endmodule
